// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (read-only)
// and load/store. Only one transaction is outstanding at a time.
// Each transaction runs IDLE (arbitrate) -> REQ (until i_mem_ready) -> [WAIT (until
// i_mem_rvalid), reads only] -> DONE (one-cycle done pulse) -> IDLE.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_if_req/i_if_addr                fetch read request
//   o_if_gnt/o_if_done/o_if_rdata     fetch grant pulse, done pulse, read data
//   o_stall_if                        fetch-stage stall
//   i_ls_req/i_ls_wren/i_ls_addr/i_ls_wdata/i_ls_bmask    load/store request
//   o_ls_gnt/o_ls_done/o_ls_rdata     load/store grant pulse, done pulse, load data
//   o_stall_ls                        memory-stage stall
//   o_mem_req/o_mem_wren/o_mem_addr/o_mem_wdata/o_mem_bmask   memory request side
//   i_mem_ready/i_mem_rvalid/i_mem_rdata                      memory response side
//   o_bus_err                         read-timeout pulse
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the read timeout. When the
// macro is undefined, WAIT waits indefinitely and o_bus_err is tied to 0.
// MAX_STARVE must be at least 1.

module mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_STARVE     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_done,
    output logic [DATA_W-1:0]     o_if_rdata,
    output logic                  o_stall_if,
    input  logic                  i_ls_req,
    input  logic                  i_ls_wren,
    input  logic [ADDR_W-1:0]     i_ls_addr,
    input  logic [DATA_W-1:0]     i_ls_wdata,
    input  logic [DATA_W/8-1:0]   i_ls_bmask,
    output logic                  o_ls_gnt,
    output logic                  o_ls_done,
    output logic [DATA_W-1:0]     o_ls_rdata,
    output logic                  o_stall_ls,
    output logic                  o_mem_req,
    output logic                  o_mem_wren,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_bmask,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_bus_err
);

    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);
    localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(MAX_STARVE);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} arbState_e;

    arbState_e           state;
    logic                ownerIf;    // 1: fetch owns the current transaction
    logic [STARVE_W-1:0] starveCnt;
    logic                ifWins;
    logic                lsWins;
    logic                arbIdle;
    logic                xferBusy;
    logic                timeoutHit;

    always_comb begin
        // Load/store has priority unless fetch has lost MAX_STARVE times in a row.
        ifWins   = i_if_req & (~i_ls_req | (starveCnt >= STARVE_SAT));
        lsWins   = i_ls_req & ~ifWins;
        // Input-derived outputs are gated so that every output is 0 while in reset.
        arbIdle  = i_rst_n & (state == StIdle);
        xferBusy = (state == StReq) | (state == StWait);
    end

    assign o_if_gnt   = arbIdle & ifWins;
    assign o_ls_gnt   = arbIdle & lsWins;
    assign o_if_done  = (state == StDone) & ownerIf;
    assign o_ls_done  = (state == StDone) & ~ownerIf;
    assign o_mem_req  = (state == StReq);
    assign o_stall_if = i_rst_n & ((i_if_req & ~o_if_done) | (xferBusy & ownerIf));
    assign o_stall_ls = i_rst_n & ((i_ls_req & ~o_ls_done) | (xferBusy & ~ownerIf));
    assign o_bus_err  = timeoutHit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [TO_W-1:0] toCnt;

    // toCnt counts completed WAIT cycles, so the TIMEOUT_CYCLES-th WAIT cycle fires.
    assign timeoutHit = (state == StWait) & ~i_mem_rvalid & (toCnt == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            toCnt <= '0;
        end else if (state != StWait) begin
            toCnt <= '0;
        end else if (!timeoutHit) begin
            toCnt <= toCnt + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= StIdle;
            ownerIf     <= 1'b0;
            starveCnt   <= '0;
            o_mem_wren  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_if_rdata  <= '0;
            o_ls_rdata  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!i_if_req || ifWins) begin
                        starveCnt <= '0;
                    end else if (i_ls_req && (starveCnt != STARVE_SAT)) begin
                        starveCnt <= starveCnt + 1'b1;
                    end
                    if (ifWins) begin
                        ownerIf     <= 1'b1;
                        o_mem_wren  <= 1'b0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= '0;
                        o_mem_bmask <= '0;
                        state       <= StReq;
                    end else if (lsWins) begin
                        ownerIf     <= 1'b0;
                        o_mem_wren  <= i_ls_wren;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_wdata <= i_ls_wdata;
                        o_mem_bmask <= i_ls_bmask;
                        state       <= StReq;
                    end
                end
                StReq: begin
                    // rvalid seen here belongs to no accepted request and is dropped.
                    if (i_mem_ready) begin
                        state <= o_mem_wren ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (i_mem_rvalid) begin
                        if (ownerIf) begin
                            o_if_rdata <= i_mem_rdata;
                        end else begin
                            o_ls_rdata <= i_mem_rdata;
                        end
                        state <= StDone;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timeoutHit) begin
                        if (ownerIf) begin
                            o_if_rdata <= ERR_DATA;
                        end else begin
                            o_ls_rdata <= ERR_DATA;
                        end
                        state <= StDone;
                    end
`endif
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
